// File: rtl/scratch_pad_loader.sv
// rtl/scratch_pad_loader.sv - streams a block of memory words into a downstream FIFO
//
// Purpose:
//    On a one-cycle start request, reads len consecutive words from a memory
//    with one-cycle read latency, starting at base_addr, and writes them in
//    address order into a FIFO that may apply backpressure through fifo_full.
//    Returning read data lands in a 2-entry skid buffer. A read is only
//    issued when the buffer is guaranteed to have room for it, so no word
//    is ever lost.
//
// Optional feature:
//    SCRATCH_PAD_LOADER_STRIDE_EN - adds a stride input sampled with start.
//    The read address then advances by stride (mod 2^ADDR_WIDTH) per read
//    instead of by 1.
//
// Ports:
//    clk        in   clock, all state changes on the rising edge
//    rstn       in   synchronous active-low reset
//    start      in   one-cycle transfer request, accepted only while idle
//    base_addr  in   first memory address, sampled with start
//    len        in   transfer length in words, sampled with start
//    stride     in   address increment, sampled with start (stride build only)
//    mem_ren    out  memory read strobe
//    mem_addr   out  memory read address, valid while mem_ren=1
//    mem_rdata  in   memory read data, valid one cycle after mem_ren
//    fifo_full  in   downstream FIFO full flag
//    fifo_wen   out  FIFO write enable
//    fifo_din   out  FIFO write data, valid while fifo_wen=1
//    busy       out  high from the cycle after an accepted start until done
//    done       out  one-cycle completion pulse
module scratch_pad_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
`ifdef SCRATCH_PAD_LOADER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   output logic                  mem_ren,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  fifo_full,
   output logic                  fifo_wen,
   output logic [DATA_WIDTH-1:0] fifo_din,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_step;
   logic [LEN_WIDTH-1:0]  issue_left_q;
   logic [LEN_WIDTH-1:0]  write_left_q;
   logic                  rd_pend_q;
   logic [DATA_WIDTH-1:0] skid0_q;
   logic [DATA_WIDTH-1:0] skid1_q;
   logic [1:0]            skid_cnt_q;
   logic                  done_q;

   logic                  accept;
   logic                  issue;
   logic                  last_write;
   logic [1:0]            occ_after;

`ifdef SCRATCH_PAD_LOADER_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride_q;
   assign addr_step = stride_q;
`else
   assign addr_step = ADDR_WIDTH'(1);
`endif

   assign accept = (state_q == IDLE) && start;

   // The head of the skid buffer goes out whenever the FIFO can take it.
   assign fifo_wen = (skid_cnt_q != 2'd0) && !fifo_full;
   assign fifo_din = skid0_q;

   // Words held plus the word landing this cycle, minus the word leaving.
   // Upper bound is 2 (a full buffer with nothing in flight), so 2 bits suffice.
   assign occ_after = skid_cnt_q + {1'b0, rd_pend_q} - {1'b0, fifo_wen};

   // A new read is only issued if its data is guaranteed a free slot when it
   // returns next cycle, even if the FIFO stalls from then on.
   assign issue      = (state_q == FETCH) && (occ_after < 2'd2);
   assign mem_ren    = issue;
   assign mem_addr   = addr_q;
   assign last_write = fifo_wen && (write_left_q == LEN_WIDTH'(1));

   assign busy = (state_q != IDLE);
   assign done = done_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && (len != '0)) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (issue && (issue_left_q == LEN_WIDTH'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_write) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Transfer bookkeeping: address, read and write counters, completion pulse.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q       <= '0;
         issue_left_q <= '0;
         write_left_q <= '0;
         rd_pend_q    <= 1'b0;
         done_q       <= 1'b0;
`ifdef SCRATCH_PAD_LOADER_STRIDE_EN
         stride_q     <= '0;
`endif
      end else begin
         // A zero-length request completes immediately without leaving IDLE.
         done_q    <= (accept && (len == '0)) || ((state_q == DRAIN) && last_write);
         // Cleared on reset, so data returning for a read issued just before
         // a reset is never captured.
         rd_pend_q <= issue;
         if (accept) begin
            addr_q       <= base_addr;
            issue_left_q <= len;
            write_left_q <= len;
`ifdef SCRATCH_PAD_LOADER_STRIDE_EN
            stride_q     <= stride;
`endif
         end else begin
            if (issue) begin
               addr_q       <= addr_q + addr_step;
               issue_left_q <= issue_left_q - LEN_WIDTH'(1);
            end
            if (fifo_wen) begin
               write_left_q <= write_left_q - LEN_WIDTH'(1);
            end
         end
      end
   end

   // Two-entry skid buffer; skid0_q is always the oldest word. A pop and a
   // push in the same cycle shift and refill without losing either word.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         skid0_q    <= '0;
         skid1_q    <= '0;
         skid_cnt_q <= 2'd0;
      end else begin
         case ({fifo_wen, rd_pend_q})
            2'b01: begin
               if (skid_cnt_q == 2'd0) begin
                  skid0_q <= mem_rdata;
               end else begin
                  skid1_q <= mem_rdata;
               end
               skid_cnt_q <= skid_cnt_q + 2'd1;
            end
            2'b10: begin
               skid0_q    <= skid1_q;
               skid_cnt_q <= skid_cnt_q - 2'd1;
            end
            2'b11: begin
               if (skid_cnt_q == 2'd1) begin
                  skid0_q <= mem_rdata;
               end else begin
                  skid0_q <= skid1_q;
                  skid1_q <= mem_rdata;
               end
            end
            default: begin
               skid_cnt_q <= skid_cnt_q;
            end
         endcase
      end
   end

endmodule
